// File: rtl/apb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_cfg_master
// Brief    : Single-outstanding APB3 initiator on the reference clock. Turns a
//            valid/ready request into SETUP/ACCESS phases and returns read
//            data / error on a valid/ready response channel.
// Options  : APB_CFG_MASTER_TIMEOUT_EN - abort an ACCESS phase after
//            TIMEOUT_CYCLES cycles without PREADY (error + timeout flag).
// Revision : 1.0 - initial release
// ============================================================================
module apb_cfg_master #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  ref_clk_i,
    input  logic                  rstpin_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic                  req_write_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]           PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Counter width is fixed; reject timeouts that cannot be represented.
    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1048575) begin : g_bad_timeout
            $error("apb_cfg_master: TIMEOUT_CYCLES must be in 1..2^20-1");
        end
    endgenerate

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
    logic [31:0]           pwdata_q,  pwdata_d;
    logic                  pwrite_q,  pwrite_d;
    logic                  psel_q,    psel_d;
    logic                  penable_q, penable_d;
    logic                  rvalid_q,  rvalid_d;
    logic [31:0]           rdata_q,   rdata_d;
    logic                  rerr_q,    rerr_d;

`ifdef APB_CFG_MASTER_TIMEOUT_EN
    // Loaded in SETUP so that the count reaches zero on the last allowed ACCESS cycle.
    localparam logic [19:0] TMO_LOAD = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TMO_RDATA = 32'hDEADBEEF;

    logic [19:0] cnt_q, cnt_d;
    logic        rtmo_q, rtmo_d;
`endif

    // State and registered outputs; async reset drops the APB strobes at once.
    always_ff @(posedge ref_clk_i or negedge rstpin_ni) begin
        if (!rstpin_ni) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
            cnt_q     <= '0;
            rtmo_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
            cnt_q     <= cnt_d;
            rtmo_q    <= rtmo_d;
`endif
        end
    end

    // Next-state and next-output logic; everything holds unless a phase changes it.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
        cnt_d     = cnt_q;
        rtmo_d    = rtmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // Request fields are sampled only here.
                if (req_valid_i) begin
                    paddr_d  = req_addr_i;
                    pwdata_d = req_wdata_i;
                    pwrite_d = req_write_i;
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
                cnt_d     = TMO_LOAD;
`endif
            end
            ST_ACCESS: begin
                // A ready slave wins even on the cycle the timeout would expire.
                if (PREADY) begin
                    rdata_d   = pwrite_q ? 32'h0 : PRDATA;
                    rerr_d    = PSLVERR;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    state_d   = ST_RESP;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
                    rtmo_d    = 1'b0;
                end else if (cnt_q == '0) begin
                    rdata_d   = TMO_RDATA;
                    rerr_d    = 1'b1;
                    rtmo_d    = 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d     = cnt_q - 20'd1;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign rsp_valid_o = rvalid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = rerr_q;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
    assign rsp_timeout_o = rtmo_q;
`else
    assign rsp_timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cfg_master
// Brief    : Self-checking bench for apb_cfg_master. Each transaction is
//            planned as a timeline (accept edge, ACCESS length, response
//            release edge); expected outputs every cycle follow from that plan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_cfg_master;

    localparam int AW  = 12;
    localparam int TMO = 4;

    logic          ref_clk_i = 1'b0;
    logic          rstpin_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i = '0;
    logic [31:0]   req_wdata_i = '0;
    logic          req_write_i = 1'b0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic          busy_o;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    apb_cfg_master #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .ref_clk_i     (ref_clk_i),
        .rstpin_ni     (rstpin_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_write_i   (req_write_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .busy_o        (busy_o),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PWRITE        (PWRITE),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR)
    );

    always #5 ref_clk_i = ~ref_clk_i;

    // Counters and the cycle index (number of rising edges seen).
    int n_chk = 0;
    int n_fail = 0;
    int ec = 0;
    bit chk_en = 1'b0;

    // Transaction plan: accepted at edge m_A, m_L ACCESS cycles, response released at edge m_R.
    bit            m_act = 1'b0;
    int            m_A = 0, m_L = 0, m_R = 0;
    logic [AW-1:0] m_addr = '0, m_addr_prev = '0;
    logic [31:0]   m_wdata = '0, m_wdata_prev = '0;
    logic          m_write = 1'b0, m_write_prev = 1'b0;
    logic [31:0]   m_rdata = '0;
    logic          m_err = 1'b0, m_tmo = 1'b0;

    // Observations used by the hand-computed literal checks.
    int          mon_psel, mon_pen, mon_rv, mon_first_psel, mon_first_rv;
    logic [31:0] mon_rdata;
    logic        mon_err, mon_tmo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, ec);
        end
    endtask

    task automatic compare();
        logic e_psel, e_pen, e_rv, e_busy;
        e_psel = m_act && ec >= m_A && ec <= m_A + m_L;
        e_pen  = m_act && ec >= m_A + 1 && ec <= m_A + m_L;
        e_rv   = m_act && ec >= m_A + m_L + 1 && ec < m_R;
        e_busy = m_act && ec >= m_A && ec < m_R;
        chk("PSEL",        32'(PSEL),        32'(e_psel));
        chk("PENABLE",     32'(PENABLE),     32'(e_pen));
        chk("rsp_valid",   32'(rsp_valid_o), 32'(e_rv));
        chk("busy",        32'(busy_o),      32'(e_busy));
        chk("req_ready",   32'(req_ready_o), 32'(!e_busy));
        chk("PADDR",       32'(PADDR),  32'(ec >= m_A ? m_addr  : m_addr_prev));
        chk("PWDATA",      PWDATA,           (ec >= m_A ? m_wdata : m_wdata_prev));
        chk("PWRITE",      32'(PWRITE), 32'(ec >= m_A ? m_write : m_write_prev));
        if (e_rv) begin
            chk("rsp_rdata",   rsp_rdata_o,         m_rdata);
            chk("rsp_err",     32'(rsp_err_o),      32'(m_err));
            chk("rsp_timeout", 32'(rsp_timeout_o),  32'(m_tmo));
        end
        mon_psel += int'(PSEL);
        mon_pen  += int'(PENABLE);
        mon_rv   += int'(rsp_valid_o);
        if (PSEL && mon_first_psel < 0) mon_first_psel = ec;
        if (rsp_valid_o && mon_first_rv < 0) begin
            mon_first_rv = ec;
            mon_rdata    = rsp_rdata_o;
            mon_err      = rsp_err_o;
            mon_tmo      = rsp_timeout_o;
        end
    endtask

    // End of current cycle: compare at the falling edge, then move to just after the next rise.
    task automatic step();
        @(negedge ref_clk_i);
        if (chk_en) compare();
        @(posedge ref_clk_i);
        ec++;
        #1;
    endtask

    task automatic junk_slave();
        PREADY  = 1'($urandom);
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid_i = 1'b0;
            req_addr_i  = AW'($urandom);
            rsp_ready_i = 1'($urandom);
            junk_slave();
            step();
        end
    endtask

    // ready_at: ACCESS cycle (1-based) on which the slave answers; 0 = never.
    task automatic run_txn(input logic [AW-1:0] a, input logic [31:0] wd, input logic wr,
                           input int ready_at, input logic [31:0] prd, input logic serr,
                           input int dly, input logic hold_v);
        int A;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_wdata_i = wd;
        req_write_i = wr;
        rsp_ready_i = 1'($urandom);
        junk_slave();
        A = ec + 1;
        m_addr_prev  = m_addr;  m_addr  = a;
        m_wdata_prev = m_wdata; m_wdata = wd;
        m_write_prev = m_write; m_write = wr;
`ifdef APB_CFG_MASTER_TIMEOUT_EN
        if (ready_at < 1 || ready_at > TMO) begin
            m_L = TMO; m_tmo = 1'b1;
        end else begin
            m_L = ready_at; m_tmo = 1'b0;
        end
`else
        m_L = ready_at; m_tmo = 1'b0;
`endif
        if (m_tmo) begin
            m_rdata = 32'hDEADBEEF; m_err = 1'b1;
        end else begin
            m_rdata = wr ? 32'h0 : prd; m_err = serr;
        end
        m_A = A; m_R = A + m_L + 2 + dly; m_act = 1'b1;
        mon_psel = 0; mon_pen = 0; mon_rv = 0; mon_first_psel = -1; mon_first_rv = -1;
        step();
        while (ec < m_R) begin
            req_valid_i = hold_v;
            req_addr_i  = AW'($urandom);
            req_wdata_i = $urandom;
            req_write_i = 1'($urandom);
            if (ec >= A + 1 && ec <= A + m_L) begin
                PREADY  = (ec - A == ready_at);
                PRDATA  = PREADY ? prd : $urandom;
                PSLVERR = PREADY ? serr : 1'($urandom);
            end else begin
                junk_slave();
            end
            if (ec >= A + m_L + 1) rsp_ready_i = (ec == m_R - 1);
            else                   rsp_ready_i = 1'($urandom);
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int lo;
        // Reset values.
        step(); step(); step();
        chk("reset PSEL",      32'(PSEL),          32'h0);
        chk("reset PENABLE",   32'(PENABLE),       32'h0);
        chk("reset PADDR",     32'(PADDR),         32'h0);
        chk("reset PWDATA",    PWDATA,             32'h0);
        chk("reset rsp_valid", 32'(rsp_valid_o),   32'h0);
        chk("reset rdata",     rsp_rdata_o,        32'h0);
        chk("reset err",       32'(rsp_err_o),     32'h0);
        chk("reset timeout",   32'(rsp_timeout_o), 32'h0);
        chk("reset ready",     32'(req_ready_o),   32'h1);
        chk("reset busy",      32'(busy_o),        32'h0);
        #2 rstpin_ni = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // Write 0x0D0, slave ready on 3rd ACCESS cycle.
        run_txn(12'h0D0, 32'h0000_1234, 1'b1, 3, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        chk("wr psel cycles", 32'(mon_psel),  32'd4);
        chk("wr pen cycles",  32'(mon_pen),   32'd3);
        chk("wr rdata",       mon_rdata,      32'h0);
        chk("wr err",         32'(mon_err),   32'h0);
        idle(1);

        // Read 0x0F8, ready on 1st ACCESS cycle: response 3 cycles after the accept cycle.
        run_txn(12'h0F8, 32'h0, 1'b0, 1, 32'h0000_00A5, 1'b0, 0, 1'b0);
        chk("rd latency",     32'(mon_first_rv - (m_A - 1)), 32'd3);
        chk("rd rdata",       mon_rdata,      32'h0000_00A5);
        chk("rd err",         32'(mon_err),   32'h0);
        idle(1);

        // Read with slave error.
        run_txn(12'h5FC, 32'h0, 1'b0, 2, 32'h0095_BEEF, 1'b1, 0, 1'b0);
        chk("err rdata",      mon_rdata,      32'h0095_BEEF);
        chk("err err",        32'(mon_err),   32'h1);
        chk("err timeout",    32'(mon_tmo),   32'h0);
        idle(1);

        // Response back-pressure for 5 cycles with a request waiting.
        run_txn(12'h010, 32'hA5A5_0001, 1'b1, 1, 32'h0, 1'b0, 5, 1'b1);
        chk("hold rv cycles", 32'(mon_rv),    32'd6);
        r0 = m_R;
        run_txn(12'h014, 32'h0, 1'b0, 1, 32'h1357_9BDF, 1'b0, 0, 1'b0);
        chk("b2b accept",     32'(mon_first_psel - r0), 32'd1);
        chk("b2b rdata",      mon_rdata,      32'h1357_9BDF);
        idle(1);

`ifdef APB_CFG_MASTER_TIMEOUT_EN
        // Slave never ready: exactly TMO ACCESS cycles then abort.
        run_txn(12'h020, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1, 1'b0);
        chk("tmo pen cycles", 32'(mon_pen),   32'd4);
        chk("tmo rdata",      mon_rdata,      32'hDEAD_BEEF);
        chk("tmo err",        32'(mon_err),   32'h1);
        chk("tmo flag",       32'(mon_tmo),   32'h1);
        idle(1);
        // Ready on the expiry cycle wins.
        run_txn(12'h024, 32'h0, 1'b0, 4, 32'h0000_0042, 1'b0, 0, 1'b0);
        chk("edge pen cycles", 32'(mon_pen),  32'd4);
        chk("edge rdata",     mon_rdata,      32'h0000_0042);
        chk("edge flag",      32'(mon_tmo),   32'h0);
        idle(1);
`else
        // Without the timeout a slow slave is simply waited for.
        run_txn(12'h020, 32'h0, 1'b0, 12, 32'h0000_0042, 1'b0, 0, 1'b0);
        chk("slow pen cycles", 32'(mon_pen),  32'd12);
        chk("slow rdata",     mon_rdata,      32'h0000_0042);
        chk("slow flag",      32'(mon_tmo),   32'h0);
        idle(1);
`endif

        // Async reset during ACCESS.
        req_valid_i = 1'b1; req_addr_i = 12'h123; req_write_i = 1'b0; PREADY = 1'b0;
        m_A = ec + 1; m_L = 1000; m_R = m_A + 2000; m_act = 1'b1;
        m_addr_prev = m_addr; m_addr = 12'h123;
        m_wdata_prev = m_wdata; m_wdata = req_wdata_i;
        m_write_prev = m_write; m_write = 1'b0;
        step();
        req_valid_i = 1'b0; PREADY = 1'b0;
        step();
        PREADY = 1'b0;
        step();
        chk_en = 1'b0;
        #2 rstpin_ni = 1'b0;
        #1;
        chk("arst PSEL",      32'(PSEL),        32'h0);
        chk("arst PENABLE",   32'(PENABLE),     32'h0);
        chk("arst rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("arst ready",     32'(req_ready_o), 32'h1);
        chk("arst PADDR",     32'(PADDR),       32'h0);
        step(); step();
        #2 rstpin_ni = 1'b1;
        m_act = 1'b0; m_A = 0; m_addr = '0; m_wdata = '0; m_write = 1'b0;
        chk_en = 1'b1;
        idle(1);
        run_txn(12'h0F8, 32'h0, 1'b0, 2, 32'hCAFE_0001, 1'b0, 1, 1'b0);
        chk("post-rst rdata", mon_rdata, 32'hCAFE_0001);
        idle(1);

        // Randomized traffic.
`ifdef APB_CFG_MASTER_TIMEOUT_EN
        lo = 0;
`else
        lo = 1;
`endif
        for (int t = 0; t < 40; t++) begin
            logic hv;
            hv = 1'($urandom);
            run_txn(AW'($urandom), $urandom, 1'($urandom), $urandom_range(6, lo),
                    $urandom, 1'($urandom), $urandom_range(3, 0), hv);
            if (!hv) idle($urandom_range(2, 0));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
